// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the data_ram arbiter: FSM state codes, master IDs and the
// request bundle latched into the RAM-side output registers.
package data_ram_arbiter_pkg;

  localparam logic        RST_ENABLE        = 1'b1;
  localparam int unsigned DEFAULT_MAX_BURST = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } master_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } ram_req_t;

  function automatic ram_req_t pack_req(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [3:0]  sel,
                                        input logic [31:0] data);
    ram_req_t r;
    r.we   = we;
    r.addr = addr;
    r.sel  = sel;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick. force0 hands master 0 the grant
// after a forced burst-lock release so it cannot be starved.
module rr_arb2
  import data_ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_e    last,
  input  logic       force0,
  output master_e    gnt
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt = MST_CPU;
    if (force0 && req[0]) begin
      gnt = MST_CPU;
    end else if (req == 2'b11) begin
      gnt = (last == MST_CPU) ? MST_DMA : MST_CPU;
    end else if (req[1]) begin
      gnt = MST_DMA;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter and access sequencer for the single-port data_ram:
// IDLE arbitrates and latches the request, ACCESS drives the RAM, DONE acks.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_data_o,
  output logic        m0_stall_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_lock_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_data_o,

  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  localparam int              CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  state_e           state_q, state_n;
  master_e          gnt_q, last_q, last_n, arb_gnt, win;
  logic             lock_q, lock_n, lock_hold, force0, take;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       req_vec, ack_q;
  ram_req_t         m0_r, m1_r, win_req;

  logic             ce_q, we_q;
  logic [31:0]      addr_q, wdata_q, m0_rdata_q, m1_rdata_q;
  logic [3:0]       sel_q;

  assign req_vec = {m1_req_i, m0_req_i};
  assign m0_r    = pack_req(m0_we_i, m0_addr_i, m0_sel_i, m0_data_i);
  assign m1_r    = pack_req(m1_we_i, m1_addr_i, m1_sel_i, m1_data_i);

  // The lock survives an arbitration only while master 1 keeps both its
  // request and lock up and still has burst budget left.
  assign lock_hold = lock_q & m1_lock_i & m1_req_i & (cnt_q < BURST_LIMIT);
  assign force0    = lock_q & ~lock_hold;

  rr_arb2 u_rr_arb2 (
    .req    (req_vec),
    .last   (last_q),
    .force0 (force0),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_n = state_q;
    take    = 1'b0;
    lock_n  = lock_q;
    cnt_n   = cnt_q;
    last_n  = last_q;
    win     = lock_hold ? MST_DMA : arb_gnt;
    win_req = (win == MST_DMA) ? m1_r : m0_r;

    unique case (state_q)
      ST_IDLE: begin
        lock_n = 1'b0;
        cnt_n  = '0;
        if (|req_vec) begin
          take    = 1'b1;
          state_n = ST_ACCESS;
          // The tie-turn pointer moves only on contested arbitrations.
          if (&req_vec) last_n = win;
          if (win == MST_DMA && m1_lock_i) begin
            lock_n = 1'b1;
            cnt_n  = (lock_hold ? cnt_q : '0) + CNT_W'(1);
          end
        end
      end
      ST_ACCESS: state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= ST_IDLE;
      gnt_q      <= MST_CPU;
      last_q     <= MST_DMA;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      ack_q      <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_n;
      lock_q  <= lock_n;
      cnt_q   <= cnt_n;
      last_q  <= last_n;
      ack_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            ce_q    <= 1'b1;
            we_q    <= win_req.we;
            addr_q  <= win_req.addr;
            sel_q   <= win_req.sel;
            wdata_q <= win_req.data;
            gnt_q   <= win;
          end
        end
        ST_ACCESS: begin
          ce_q  <= 1'b0;
          we_q  <= 1'b0;
          ack_q <= (gnt_q == MST_DMA) ? 2'b10 : 2'b01;
          if (!we_q) begin
            if (gnt_q == MST_DMA) m1_rdata_q <= ram_data_i;
            else                  m0_rdata_q <= ram_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_data_o  = m0_rdata_q;
  assign m1_data_o  = m1_rdata_q;
  assign m0_stall_o = m0_req_i & ~ack_q[0];

  // Reset gates the strobes combinationally so an in-flight write never lands.
  assign ram_ce_o   = ce_q & ~rst;
  assign ram_we_o   = we_q & ce_q & ~rst;
  assign ram_addr_o = addr_q;
  assign ram_sel_o  = sel_q;
  assign ram_data_o = wdata_q;

endmodule
